adder_multicycle: RTL and testbench



---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_n.sv | 24 ++
 rtl/adder_multicycle.sv | 163 ++++++++++++++++
 tb/tb_adder_multicycle.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
// Holds the controller state encoding and the chunk-count helper used at elaboration.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } adder_mc_state_t;

    function automatic int chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Plain N-bit ripple-carry adder, the single arithmetic resource of the multi-cycle adder.
// Purely combinational: sum = a + b + c_in, with c_out the carry out of bit N-1.
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out = carry[N];

endmodule

// File: rtl/adder_multicycle.sv
// WIDTH-bit adder built from one CHUNK-bit ripple adder, one chunk per cycle, LSB chunk first.
// Valid/ready on both sides; result is held in S_DONE until the consumer takes it.
module adder_multicycle
    import adder_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int K     = chunks(WIDTH, CHUNK);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || K < 1) begin : g_bad_cfg
        $error("adder_multicycle: WIDTH must be a positive multiple of CHUNK");
    end

    adder_mc_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] add_sum;
    logic             add_cout;

    // Chunk select by explicit compare so no index can ever fall outside 0..K-1.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    adder_n #(
        .N(CHUNK)
    ) u_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .c_in (carry_q),
        .sum  (add_sum),
        .c_out(add_cout)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = rst_n;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                for (int i = 0; i < K; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Top chunk is being written now, so its MSB is the final sign bit.
                    c_out_d = add_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (add_sum[CHUNK-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = c_in;
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Self-checking bench: a 128/32 instance for the main scenarios plus a 32/32 (K=1) instance.
// Expected results come from plain wide arithmetic on the operands.
module tb_adder_multicycle;

    localparam int W  = 128;
    localparam int C  = 32;
    localparam int K  = W / C;
    localparam int W1 = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         busy;

    logic          in_valid_k;
    logic          in_ready_k;
    logic [W1-1:0] a_k;
    logic [W1-1:0] b_k;
    logic          c_in_k;
    logic          out_valid_k;
    logic          out_ready_k;
    logic [W1-1:0] sum_k;
    logic          c_out_k;
    logic          overflow_k;
    logic          busy_k;

    int n_cmp;
    int n_fail;

    adder_multicycle #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .busy     (busy)
    );

    adder_multicycle #(.WIDTH(W1), .CHUNK(W1)) dut_k1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_k),
        .in_ready (in_ready_k),
        .a        (a_k),
        .b        (b_k),
        .c_in     (c_in_k),
        .out_valid(out_valid_k),
        .out_ready(out_ready_k),
        .sum      (sum_k),
        .c_out    (c_out_k),
        .overflow (overflow_k),
        .busy     (busy_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: {overflow, c_out, sum} from unsigned and signed wide sums.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rc);
        logic [W:0]        usum;
        logic signed [W:0] ssum;
        logic              ovf;
        usum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        ssum = $signed({ra[W-1], ra}) + $signed({rb[W-1], rb}) + $signed({{W{1'b0}}, rc});
        ovf  = (ssum > $signed({2'b00, {(W-1){1'b1}}})) || (ssum < -$signed({2'b01, {(W-1){1'b0}}}));
        return {ovf, usum[W], usum[W-1:0]};
    endfunction

    // Present one operand set from idle, scramble inputs after acceptance, count cycles to out_valid.
    task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                           output int lat);
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = rand_w(); b = rand_w(); c_in = 1'($urandom_range(0, 1));
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic pop_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_valid_k = 1'b1; a = rand_w(); b = rand_w();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if ({c_out, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {c_out, overflow}); end
        in_valid = 1'b0; in_valid_k = 1'b0; rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
        n_cmp++; if (busy_k !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy_k1 got=%b exp=0", busy_k); end
        $display("reset done");
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic [W-1:0] exp_sum, input logic exp_c,
                            input logic exp_ovf);
        int lat;
        send_op(ta, tb_v, tc, lat);
        $display("op %s a=%h b=%h cin=%0d -> sum=%h c_out=%0d ovf=%0d lat=%0d",
                 name, ta, tb_v, tc, sum, c_out, overflow, lat);
        n_cmp++; if (lat !== K) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, K); end
        n_cmp++; if (sum !== exp_sum) begin n_fail++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp_sum); end
        n_cmp++; if (c_out !== exp_c) begin n_fail++; $display("FAIL %s_c_out got=%b exp=%b", name, c_out, exp_c); end
        n_cmp++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL %s_overflow got=%b exp=%b", name, overflow, exp_ovf); end
        pop_result();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after_pop got=%b exp=0", name, busy); end
    endtask

    task automatic test_carry_ripple();
        check_op("ripple", {W{1'b1}}, 128'd1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        check_op("ovf_pos", {1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        check_op("ovf_neg", {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] exp;
        for (int i = 0; i < 16; i++) begin
            ra = rand_w(); rb = rand_w(); rc = 1'($urandom_range(0, 1));
            if (i == 0) rb = ~ra;
            if (i == 1) begin ra[W-1] = 1'b0; rb[W-1] = 1'b0; end
            exp = ref_model(ra, rb, rc);
            check_op("rand", ra, rb, rc, exp[W-1:0], exp[W], exp[W+1]);
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [W-1:0] ra, rb;
        logic [W+1:0] exp;
        ra = rand_w(); rb = rand_w();
        exp = ref_model(ra, rb, 1'b0);
        send_op(ra, rb, 1'b0, lat);
        n_cmp++; if (lat !== K) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, K); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = rand_w(); b = rand_w();
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (sum !== exp[W-1:0] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", i, sum, out_valid, exp[W-1:0]);
            end
        end
        $display("op bp_hold sum=%h held 5 cycles", sum);
        a = 128'd5; b = 128'd7; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; a = rand_w(); b = rand_w();
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        $display("op b2b a=5 b=7 -> sum=%h lat=%0d", sum, lat);
        n_cmp++; if (lat !== K) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, K); end
        n_cmp++; if (sum !== 128'd12) begin n_fail++; $display("FAIL b2b_sum got=%h exp=c", sum); end
        pop_result();
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] exp;
        ra = rand_w(); rb = rand_w(); rc = 1'b1;
        exp = ref_model(ra, rb, rc);
        send_op(ra, rb, rc, lat);
        for (int n = 0; n < 4; n++) begin
            n_cmp++; if ({overflow, c_out, sum} !== exp) begin
                n_fail++; $display("FAIL chain%0d_result got=%b/%b/%h exp=%b/%b/%h", n, overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
            end
            ra = rand_w(); rb = rand_w(); rc = 1'($urandom_range(0, 1));
            a = ra; b = rb; c_in = rc; in_valid = 1'b1; out_ready = 1'b1;
            exp = ref_model(ra, rb, rc);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0; a = rand_w(); b = rand_w();
            lat = 0;
            while (lat < 50) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (out_valid) break;
            end
            $display("op chain%0d a=%h b=%h cin=%0d -> sum=%h lat=%0d", n, ra, rb, rc, sum, lat);
            n_cmp++; if (lat !== K) begin n_fail++; $display("FAIL chain%0d_latency got=%0d exp=%0d", n, lat, K); end
        end
        n_cmp++; if ({overflow, c_out, sum} !== exp) begin
            n_fail++; $display("FAIL chain_last_result got=%b/%b/%h exp=%b/%b/%h", overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
        end
        pop_result();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = {4{32'hDEAD_BEEF}}; b = {4{32'h1111_1111}}; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL mid_sum got=%h exp=0", sum); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("op mid_reset applied on second run cycle");
        check_op("after_mid", 128'd3, 128'd4, 1'b1, 128'd8, 1'b0, 1'b0);
    endtask

    task automatic test_k1();
        int lat;
        @(negedge clk);
        a_k = 32'hFFFF_FFFF; b_k = 32'h0; c_in_k = 1'b1; in_valid_k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_k = 1'b0; a_k = $urandom(); b_k = $urandom();
        lat = 0;
        while (lat < 50) begin
            if (out_valid_k) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op k1 a=ffffffff b=0 cin=1 -> sum=%h c_out=%0d lat=%0d", sum_k, c_out_k, lat);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL k1_latency got=%0d exp=1", lat); end
        n_cmp++; if (sum_k !== 32'h0) begin n_fail++; $display("FAIL k1_sum got=%h exp=0", sum_k); end
        n_cmp++; if (c_out_k !== 1'b1) begin n_fail++; $display("FAIL k1_c_out got=%b exp=1", c_out_k); end
        n_cmp++; if (overflow_k !== 1'b0) begin n_fail++; $display("FAIL k1_overflow got=%b exp=0", overflow_k); end
        out_ready_k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_k = 1'b0;
        n_cmp++; if (busy_k !== 1'b0) begin n_fail++; $display("FAIL k1_idle got=%b exp=0", busy_k); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        in_valid_k = 1'b0; a_k = '0; b_k = '0; c_in_k = 1'b0; out_ready_k = 1'b0;
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_k1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
